ook_modulator: RTL and testbench



---
 rtl/ook_pkg.sv | 25 ++
 rtl/ook_carrier.sv | 27 ++
 rtl/ook_modulator.sv | 145 ++++++++++++++
 tb/tb_ook_modulator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ook_pkg.sv
// Shared definitions for the OOK modulator: state encoding, frame sizes and defaults.
// Frame length depends on OOK_PARITY_EN.
package ook_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } ook_state_e;

  localparam int FRAME_SYMS_NOPAR = 10;
  localparam int FRAME_SYMS_PAR   = 11;

`ifdef OOK_PARITY_EN
  localparam int FRAME_SYMS = FRAME_SYMS_PAR;
`else
  localparam int FRAME_SYMS = FRAME_SYMS_NOPAR;
`endif

  localparam logic [15:0] DEFAULT_CW         = 16'h1555;
  localparam int          DEFAULT_SYMBOL_LEN = 256;

endpackage

// File: rtl/ook_carrier.sv
// Free-running 16-bit NCO phase accumulator; the carrier is the accumulator MSB.
// It is never re-phased, so the carrier is continuous across frames.
module ook_carrier
  import ook_pkg::*;
#(
  parameter logic [15:0] CW = DEFAULT_CW
) (
  input  logic clk,
  input  logic rst,
  output logic carrier
);

  logic [15:0] acc_q;
  logic [15:0] acc_d;

  always_comb begin
    acc_d = acc_q + CW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign carrier = acc_q[15];

endmodule

// File: rtl/ook_modulator.sv
// OOK transmitter: serialises bytes as START, 8 data bits LSB first, optional even
// parity (OOK_PARITY_EN), STOP; each symbol gates the NCO carrier for SYMBOL_LEN clocks.
module ook_modulator
  import ook_pkg::*;
#(
  parameter logic [15:0] CW         = DEFAULT_CW,
  parameter int          SYMBOL_LEN = DEFAULT_SYMBOL_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       sig,
  output logic       busy
);

  localparam int                CNT_W    = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SYMBOL_LEN - 1);

  ook_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             sig_q, sig_d;
  logic             gate;
  logic             carrier;
  logic             sym_end;
  logic             accept;
`ifdef OOK_PARITY_EN
  logic             par_q, par_d;
`endif

  ook_carrier #(.CW(CW)) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .carrier (carrier)
  );

  // ready is held low for the whole time rst is asserted, not just after the edge.
  assign ready   = (state_q == ST_IDLE) && !rst;
  assign busy    = (state_q != ST_IDLE);
  assign sig     = sig_q;
  assign accept  = valid && ready;
  assign sym_end = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
`ifdef OOK_PARITY_EN
    par_d     = par_q;
`endif
    gate      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          cnt_d     = CNT_LOAD;
          bit_idx_d = 3'd0;
          shreg_d   = data;
`ifdef OOK_PARITY_EN
          par_d     = ^data;
`endif
        end
      end
      ST_START: begin
        gate = 1'b1;
        if (sym_end) begin
          state_d = ST_DATA;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        gate = shreg_q[0];
        if (sym_end) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = CNT_LOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef OOK_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef OOK_PARITY_EN
      ST_PARITY: begin
        gate = par_q;
        if (sym_end) begin
          state_d = ST_STOP;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (sym_end) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    sig_d = gate & carrier;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      sig_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sig_q     <= sig_d;
    end
  end

  // Payload registers need no reset: they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef OOK_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_ook_modulator.sv
// Scoreboard bench for ook_modulator: expected symbol gates are queued per accepted byte
// and each SYMBOL_LEN-wide sig window is classified and compared. Honours OOK_PARITY_EN.
module tb_ook_modulator;
  import ook_pkg::*;

  localparam int          L   = 48;
  localparam logic [15:0] TCW = 16'h1555;
`ifdef OOK_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, sig, busy;

  int vectors = 0;
  int errors  = 0;
  bit sb[$];

  always #5 clk = ~clk;

  ook_modulator #(.CW(TCW), .SYMBOL_LEN(L)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .sig   (sig),
    .busy  (busy)
  );

  task automatic push_frame(input logic [7:0] b);
    sb.push_back(1'b1);
    for (int i = 0; i < 8; i++) sb.push_back(b[i]);
`ifdef OOK_PARITY_EN
    sb.push_back(^b);
`endif
    sb.push_back(1'b0);
  endtask

  // Returns the time of the accepting rising edge; checks the current cycle first.
  task automatic wait_accept(output longint t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (ready === 1'b1 && valid === 1'b1) begin
        @(posedge clk);
        t  = longint'($time);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: no handshake within 2000 cycles (ready=%b valid=%b)", ready, valid);
    end
  endtask

  // Call right after the accepting edge; consumes NSYM symbols from the scoreboard.
  task automatic capture_frame(input bit mid_stim, input bit hold, input logic [7:0] next_data);
    int busycnt = 0;
    int rdyhi   = 0;
    @(negedge clk);
    if (hold) data = next_data;
    else      valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_state: busy=%b ready=%b, required busy=1 ready=0", busy, ready);
    end
    if (busy === 1'b1) busycnt++;
    for (int s = 0; s < NSYM; s++) begin
      int   ones = 0;
      int   tr   = 0;
      int   obs;
      logic prev = 1'b0;
      bit   exp  = 1'b0;
      for (int c = 0; c < L; c++) begin
        @(negedge clk);
        if (mid_stim && s == 3) begin
          if (c == 4)  begin data = ~data; valid = 1'b1; end
          if (c == 20) valid = 1'b0;
        end
        if (c > 0 && sig !== prev) tr++;
        if (sig === 1'b1) ones++;
        prev = sig;
        if (busy === 1'b1) busycnt++;
        if (ready !== 1'b0 && !(s == NSYM - 1 && c == L - 1)) rdyhi++;
      end
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL scoreboard_empty: symbol %0d observed with no expectation", s);
      end else begin
        exp = sb.pop_front();
        obs = (tr >= 7) ? 1 : ((ones == 0) ? 0 : 2);
        vectors++;
        if (obs !== int'(exp)) begin
          errors++;
          $display("FAIL symbol_%0d: got class %0d (transitions=%0d ones=%0d), required %0d",
                   s, obs, tr, ones, exp);
        end
      end
    end
    vectors++;
    if (busycnt !== NSYM * L) begin
      errors++;
      $display("FAIL busy_length: got %0d clocks, required %0d", busycnt, NSYM * L);
    end
    vectors++;
    if (rdyhi !== 0) begin
      errors++;
      $display("FAIL ready_during_frame: high in %0d cycles, required 0", rdyhi);
    end
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: ready=%b busy=%b, required ready=1 busy=0", ready, busy);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h55;
    repeat (3) @(negedge clk);
    vectors++;
    if (sig !== 1'b0)   begin errors++; $display("FAIL reset_sig: got %b, required 0", sig); end
    vectors++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", ready); end
    vectors++;
    if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_ready: ready=%b busy=%b, required ready=1 busy=0", ready, busy);
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    longint t;
    bit     ok;
    data  = b;
    valid = 1'b1;
    push_frame(b);
    wait_accept(t, ok);
    if (ok) capture_frame(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back;
    longint t1, t2;
    bit     ok1, ok2;
    data  = 8'h00;
    valid = 1'b1;
    push_frame(8'h00);
    push_frame(8'hFF);
    wait_accept(t1, ok1);
    if (ok1) capture_frame(1'b0, 1'b1, 8'hFF);
    wait_accept(t2, ok2);
    if (ok1 && ok2) begin
      vectors++;
      if ((t2 - t1) / 10 !== longint'(NSYM * L + 1)) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d clocks, required %0d", (t2 - t1) / 10, NSYM * L + 1);
      end
      capture_frame(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_mid_frame;
    longint t;
    bit     ok;
    data  = 8'h3C;
    valid = 1'b1;
    push_frame(8'h3C);
    wait_accept(t, ok);
    if (ok) capture_frame(1'b1, 1'b0, 8'h00);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL extra_accept: busy=%b after frame, required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    longint t;
    bit     ok;
    bit     seen = 1'b0;
    data  = 8'hFF;
    valid = 1'b1;
    push_frame(8'hFF);
    wait_accept(t, ok);
    @(negedge clk);
    valid = 1'b0;
    repeat (2 * L) @(negedge clk);
    for (int i = 0; i < L && !seen; i++) begin
      if (sig === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen || !ok) begin
      errors++;
      $display("FAIL mid_data_sig: sig never high in DATA (seen=%b accepted=%b), required 1", seen, ok);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (sig !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sig=%b busy=%b ready=%b, required 0 0 0", sig, busy, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_abort: ready=%b busy=%b, required ready=1 busy=0", ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_back_to_back();
    test_mid_frame();
    test_single(8'h07);
    test_single(8'h03);
    test_reset_mid();
    test_single(8'h81);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
